// File: rtl/maj3_net_eval_if.sv
// Handshake and config bundle for maj3_net_eval; master = feature side, slave = evaluator.
// Carries the input vector, the result and the node/length programming port.
interface maj3_net_eval_if #(
  parameter int NIN   = 7,
  parameter int NODES = 8,
  parameter int SELW  = $clog2(NIN + NODES + 1),
  parameter int AW    = $clog2(NODES + 1)
);
  logic                  cfg_we;
  logic [AW-1:0]         cfg_addr;
  logic [3*(SELW+1)-1:0] cfg_data;
  logic                  cfg_busy;
  logic                  in_valid;
  logic                  in_ready;
  logic [NIN-1:0]        in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_data;

  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    input  cfg_busy, in_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    output cfg_busy, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/maj3_net_eval.sv
// Programmable MAJ3 network evaluator: one node per clock, result len edges after accept.
// Input accepted only in IDLE; result held in DONE until out_ready, no new input meanwhile.
module maj3_net_eval #(
  parameter int NIN   = 7,
  parameter int NODES = 8,
  parameter int SELW  = $clog2(NIN + NODES + 1),
  parameter int AW    = $clog2(NODES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  maj3_net_eval_if.slave  bus
);
  localparam int CW = SELW + 1;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t              state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                out_data_q;
  logic                cfg_busy_q;
  logic [3*CW-1:0]     ncfg_q [NODES];
  logic [AW-1:0]       len_q;
  logic [AW-1:0]       ctr_q;
  logic [NIN-1:0]      x_q;
  logic [NODES-1:0]    w_q;

  logic                len_wr;
  logic [AW-1:0]       len_sat;
  logic [AW-1:0]       eff_len;
  logic [3*CW-1:0]     cur_cfg;
  logic [SELW-1:0]     op_sel;
  logic                op_val;
  logic [2:0]          opv;
  logic                node_val;

  // A length write in the accept cycle must steer the IDLE exit decision.
  always_comb begin
    len_wr  = bus.cfg_we && (state_q == IDLE) && (bus.cfg_addr == AW'(NODES));
    len_sat = (bus.cfg_data[AW-1:0] > AW'(NODES)) ? AW'(NODES) : bus.cfg_data[AW-1:0];
    eff_len = len_wr ? len_sat : len_q;
  end

  // Operand fetch for node ctr; only nodes strictly below ctr are visible.
  always_comb begin
    cur_cfg = '0;
    for (int n = 0; n < NODES; n++) begin
      if (ctr_q == AW'(n)) cur_cfg = ncfg_q[n];
    end
    opv    = '0;
    op_sel = '0;
    op_val = 1'b0;
    for (int k = 0; k < 3; k++) begin
      op_sel = cur_cfg[k*CW +: SELW];
      op_val = 1'b0;
      for (int i = 0; i < NIN; i++) begin
        if (op_sel == SELW'(i + 1)) op_val = x_q[i];
      end
      for (int j = 0; j < NODES; j++) begin
        if (op_sel == SELW'(NIN + 1 + j) && AW'(j) < ctr_q) op_val = w_q[j];
      end
      opv[k] = op_val ^ cur_cfg[k*CW + SELW];
    end
    node_val = (opv[0] & opv[1]) | (opv[0] & opv[2]) | (opv[1] & opv[2]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      cfg_busy_q  <= 1'b0;
      len_q       <= '0;
      ctr_q       <= '0;
      x_q         <= '0;
      w_q         <= '0;
      for (int n = 0; n < NODES; n++) ncfg_q[n] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (len_wr) len_q <= len_sat;
          if (bus.cfg_we) begin
            for (int n = 0; n < NODES; n++) begin
              if (bus.cfg_addr == AW'(n)) ncfg_q[n] <= bus.cfg_data;
            end
          end
          if (bus.in_valid) begin
            x_q        <= bus.in_data;
            w_q        <= '0;
            ctr_q      <= '0;
            in_ready_q <= 1'b0;
            cfg_busy_q <= 1'b1;
            if (eff_len != '0) begin
              state_q <= EVAL;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= 1'b0;
            end
          end
        end
        EVAL: begin
          for (int n = 0; n < NODES; n++) begin
            if (ctr_q == AW'(n)) w_q[n] <= node_val;
          end
          if (ctr_q == len_q - AW'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= node_val;
          end else begin
            ctr_q <= ctr_q + AW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            cfg_busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.cfg_busy  = cfg_busy_q;
endmodule
